// File: rtl/lstm_pkg.sv
// Shared constants and types for the LSTM sequencing logic.
package lstm_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRACT_WIDTH = 8;

    // Fixed-point 1.0 in Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH
    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRACT_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_X,
        SETTLE,
        EMIT
    } seq_state_t;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Steps a combinational LSTM cell (instantiated by the parent) through a
// stream of inputs. Holds the recurrent c/h registers, waits a fixed settle
// time per step, captures the cell outputs and emits h on a valid/ready stream.
module lstm_seq_ctrl #(
    parameter int DATA_WIDTH    = lstm_pkg::DATA_WIDTH,
    parameter int FRACT_WIDTH   = lstm_pkg::FRACT_WIDTH,
    parameter int SEQ_LEN_W     = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SEQ_LEN_W-1:0]  seq_len,
    input  logic [DATA_WIDTH-1:0] c_init,
    input  logic [DATA_WIDTH-1:0] h_init,
    input  logic                  x_valid,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  x_ready,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_c_in,
    output logic [DATA_WIDTH-1:0] cell_h_in,
    input  logic [DATA_WIDTH-1:0] cell_c_out,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic                  h_valid,
    output logic [DATA_WIDTH-1:0] h_data,
    output logic                  h_last,
    input  logic                  h_ready,
    output logic [DATA_WIDTH-1:0] c_state,
    output logic [DATA_WIDTH-1:0] h_state,
    output logic                  busy,
    output logic                  done
);

    import lstm_pkg::*;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

    // Reject parameter sets that cannot describe a valid fixed-point word or settle time
    if (SETTLE_CYCLES < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_params
        $error("lstm_seq_ctrl: illegal SETTLE_CYCLES or FRACT_WIDTH");
    end

    seq_state_t            state_q, state_d;
    logic [SEQ_LEN_W-1:0]  len_q, len_d;
    logic [SEQ_LEN_W-1:0]  step_q, step_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
    logic                  h_valid_q, h_valid_d;
    logic                  h_last_q, h_last_d;
    logic                  x_ready_q, x_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state logic: abort outside IDLE overrides every other transition
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        step_d    = step_q;
        settle_d  = settle_q;
        x_d       = x_q;
        c_d       = c_q;
        h_d       = h_q;
        h_data_d  = h_data_q;
        h_valid_d = h_valid_q;
        h_last_d  = h_last_q;
        x_ready_d = x_ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            h_valid_d = 1'b0;
            h_last_d  = 1'b0;
            x_ready_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (seq_len != '0) begin
                            len_d     = seq_len;
                            c_d       = c_init;
                            h_d       = h_init;
                            step_d    = '0;
                            busy_d    = 1'b1;
                            x_ready_d = 1'b1;
                            state_d   = WAIT_X;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                WAIT_X: begin
                    if (x_valid && x_ready_q) begin
                        x_d       = x_data;
                        settle_d  = SETTLE_INIT;
                        x_ready_d = 1'b0;
                        state_d   = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == '0) begin
                        c_d       = cell_c_out;
                        h_d       = cell_h_out;
                        h_data_d  = cell_h_out;
                        h_valid_d = 1'b1;
                        h_last_d  = (step_q == len_q - SEQ_LEN_W'(1));
                        state_d   = EMIT;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                EMIT: begin
                    if (h_ready) begin
                        h_valid_d = 1'b0;
                        h_last_d  = 1'b0;
                        step_d    = step_q + SEQ_LEN_W'(1);
                        if (h_last_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            x_ready_d = 1'b1;
                            state_d   = WAIT_X;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            step_q    <= '0;
            settle_q  <= '0;
            x_q       <= '0;
            c_q       <= '0;
            h_q       <= '0;
            h_data_q  <= '0;
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            step_q    <= step_d;
            settle_q  <= settle_d;
            x_q       <= x_d;
            c_q       <= c_d;
            h_q       <= h_d;
            h_data_q  <= h_data_d;
            h_valid_q <= h_valid_d;
            h_last_q  <= h_last_d;
            x_ready_q <= x_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_ready   = x_ready_q;
    assign cell_x    = x_q;
    assign cell_c_in = c_q;
    assign cell_h_in = h_q;
    assign h_valid   = h_valid_q;
    assign h_data    = h_data_q;
    assign h_last    = h_last_q;
    assign c_state   = c_q;
    assign h_state   = h_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
